// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, optional parity, one or two stop bits.
// Accepts a byte on a valid/ready handshake and serialises it onto an idle-high line.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,  // clocks per serial bit, 1..65535
  parameter int unsigned PARITY       = 0,  // 0 = none, 1 = even, 2 = odd
  parameter int unsigned STOP_BITS    = 1   // 1 or 2
) (
  input  logic       clk,
  input  logic       reset,          // synchronous, active low
  input  logic [7:0] data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       outgoing_data,
  output logic       busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] ClkLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic StopLast  = (STOP_BITS > 1) ? 1'b1 : 1'b0;
  localparam logic HasParity = (PARITY != 0) ? 1'b1 : 1'b0;
  localparam logic OddParity = (PARITY == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] clk_cnt_q;   // bit-clock counter, 0..CLKS_PER_BIT-1
  logic [2:0]      bit_cnt_q;   // data bit index, 0..7
  logic            stop_cnt_q;  // stop bit index
  logic [7:0]      shift_q;     // byte latched at handshake
  logic            parity_q;    // parity bit precomputed at handshake

  logic bit_done;
  logic last_stop;
  logic handshake;

  // Bit boundary and handshake decode; ready opens in the final clock of the frame too,
  // so a waiting source can chain the next frame without an idle gap.
  assign bit_done  = (clk_cnt_q == ClkLast);
  assign last_stop = (state_q == StStop) && bit_done && (stop_cnt_q == StopLast);
  assign tx_ready  = reset && ((state_q == StIdle) || last_stop);
  assign handshake = tx_valid && tx_ready;

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      outgoing_data <= 1'b1;
      busy          <= 1'b0;
    end else begin
      // The bit clock only runs inside a frame and restarts at every bit boundary.
      if (state_q == StIdle || bit_done) begin
        clk_cnt_q <= '0;
      end else begin
        clk_cnt_q <= clk_cnt_q + CntW'(1);
      end

      case (state_q)
        StIdle: begin
          if (handshake) begin
            shift_q       <= data;
            parity_q      <= (^data) ^ OddParity;
            state_q       <= StStart;
            outgoing_data <= 1'b0;
            busy          <= 1'b1;
          end
        end

        StStart: begin
          if (bit_done) begin
            state_q       <= StData;
            bit_cnt_q     <= '0;
            outgoing_data <= shift_q[0];
          end
        end

        StData: begin
          if (bit_done) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              if (HasParity) begin
                state_q       <= StParity;
                outgoing_data <= parity_q;
              end else begin
                state_q       <= StStop;
                stop_cnt_q    <= 1'b0;
                outgoing_data <= 1'b1;
              end
            end else begin
              bit_cnt_q     <= bit_cnt_q + 3'd1;
              outgoing_data <= shift_q[bit_cnt_q + 3'd1];
            end
          end
        end

        StParity: begin
          if (bit_done) begin
            state_q       <= StStop;
            stop_cnt_q    <= 1'b0;
            outgoing_data <= 1'b1;
          end
        end

        StStop: begin
          if (bit_done) begin
            if (stop_cnt_q == StopLast) begin
              stop_cnt_q <= 1'b0;
              if (handshake) begin
                // Next frame's start bit follows directly on the line.
                shift_q       <= data;
                parity_q      <= (^data) ^ OddParity;
                state_q       <= StStart;
                outgoing_data <= 1'b0;
                busy          <= 1'b1;
              end else begin
                state_q       <= StIdle;
                outgoing_data <= 1'b1;
                busy          <= 1'b0;
              end
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q       <= StIdle;
          outgoing_data <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances cover no parity, even, odd and the one-clock-per-bit,
// two-stop-bit corner. Expected line values come from a bit-position model of the frame.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] valid = 4'b0;
  logic [3:0] ready;
  logic [3:0] line;
  logic [3:0] busy;
  logic [7:0] din [4];

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .data(din[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .outgoing_data(line[0]), .busy(busy[0])
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .data(din[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .outgoing_data(line[1]), .busy(busy[1])
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .data(din[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .outgoing_data(line[2]), .busy(busy[2])
  );
  uart_tx #(.CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .data(din[3]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .outgoing_data(line[3]), .busy(busy[3])
  );

  function automatic int cpb_of(int k);
    return (k == 3) ? 1 : 4;
  endfunction

  function automatic int par_of(int k);
    return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
  endfunction

  function automatic int sb_of(int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(int k);
    return (9 + ((par_of(k) != 0) ? 1 : 0) + sb_of(k)) * cpb_of(k);
  endfunction

  // Line value t clocks after the start bit begins.
  function automatic logic exp_bit(int k, logic [7:0] b, int t);
    int idx;
    idx = t / cpb_of(k);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (par_of(k) != 0 && idx == 9) return (par_of(k) == 1) ? (^b) : ~(^b);
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present a byte, wait (bounded) for ready, complete the handshake edge.
  task automatic start(int k, logic [7:0] b, bit hold);
    int n;
    n = 0;
    valid[k] = 1'b1;
    din[k]   = b;
    @(negedge clk);
    while (!ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d ready_wait", k), ready[k], 1'b1);
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
    din[k] = 8'($urandom);
  endtask

  task automatic check_frame(int k, logic [7:0] b, bit pulse);
    int len;
    int c;
    len = frame_len(k);
    c   = cpb_of(k);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      chk($sformatf("u%0d byte %h line t%0d", k, b, t), line[k], exp_bit(k, b, t));
      chk($sformatf("u%0d busy t%0d", k, t), busy[k], 1'b1);
      chk($sformatf("u%0d ready t%0d", k, t), ready[k], (t == len - 1) ? 1'b1 : 1'b0);
      if (pulse) begin
        if (t == 4 * c) begin
          valid[k] = 1'b1;
          din[k]   = 8'h3C;
        end else if (t == 4 * c + 1) begin
          valid[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_idle(int k, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("u%0d idle line", k), line[k], 1'b1);
      chk($sformatf("u%0d idle busy", k), busy[k], 1'b0);
      chk($sformatf("u%0d idle ready", k), ready[k], 1'b1);
    end
  endtask

  initial begin
    logic [7:0] b;
    for (int k = 0; k < 4; k++) din[k] = 8'h00;

    // Reset values, ready held low while reset is asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d rst line", k), line[k], 1'b1);
      chk($sformatf("u%0d rst busy", k), busy[k], 1'b0);
      chk($sformatf("u%0d rst ready", k), ready[k], 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("u%0d post_rst ready", k), ready[k], 1'b1);

    // Basic 0xA5 frame, 40 clocks.
    start(0, 8'hA5, 1'b0);
    check_frame(0, 8'hA5, 1'b0);
    check_idle(0, 2);

    // Even and odd parity on 0x07.
    start(1, 8'h07, 1'b0);
    check_frame(1, 8'h07, 1'b0);
    check_idle(1, 1);
    start(2, 8'h07, 1'b0);
    check_frame(2, 8'h07, 1'b0);
    check_idle(2, 1);

    // One clock per bit, two stop bits.
    start(3, 8'h81, 1'b0);
    check_frame(3, 8'h81, 1'b0);
    check_idle(3, 2);

    // Back-to-back with valid held: no idle clock between frames.
    start(0, 8'h00, 1'b1);
    din[0] = 8'hFF;
    check_frame(0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    din[0]   = 8'h00;
    check_frame(0, 8'hFF, 1'b0);
    check_idle(0, 1);

    // Request pulsed during DATA is ignored.
    start(0, 8'h96, 1'b0);
    check_frame(0, 8'h96, 1'b1);
    check_idle(0, 4);

    // Reset during data bit 3 abandons the frame.
    start(0, 8'hA5, 1'b0);
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      chk($sformatf("u0 pre_rst line t%0d", t), line[0], exp_bit(0, 8'hA5, t));
    end
    reset = 1'b0;
    @(negedge clk);
    chk("u0 midrst line", line[0], 1'b1);
    chk("u0 midrst busy", busy[0], 1'b0);
    chk("u0 midrst ready", ready[0], 1'b0);
    reset = 1'b1;
    check_idle(0, 2);
    start(0, 8'h5A, 1'b0);
    check_frame(0, 8'h5A, 1'b0);
    check_idle(0, 1);

    // Random bytes with random idle gaps on every configuration.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) begin
        b = 8'($urandom);
        start(k, b, 1'b0);
        check_frame(k, b, 1'b0);
        check_idle(k, int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
